// File: rtl/hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: constants shared by the hazard controller, its mult/div
// busy counter, its interface and benches.
//   TUSE_NONE    - d_tuse_* encoding for "operand not used"
//   MULT_CYC_DEF - default mult/multu busy cycles after issue
//   DIV_CYC_DEF  - default div/divu busy cycles after issue
//   MD_CNT_W     - width of the mult/div remaining-cycle counter
package pipe_ctrl_pkg;
  localparam logic [1:0] TUSE_NONE    = 2'd3;
  localparam int         MULT_CYC_DEF = 5;
  localparam int         DIV_CYC_DEF  = 10;
  localparam int         MD_CNT_W     = 4;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] stage_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: signal bundle between the pipeline (master) and the
// hazard controller (slave).
//   master drives: D-stage sources/tuse/md/eret, E/M destination/tnew/
//                  mtc0-EPC flags, md_start/md_is_div, irq_req
//   slave drives:  stall, bubble_e, flush_all, eret_flush, md_go,
//                  md_busy, md_cnt
interface hazard_ctrl_if import pipe_ctrl_pkg::*; ();
  reg_idx_t              d_rs, d_rt;
  stage_t                d_tuse_rs, d_tuse_rt;
  logic                  d_md, d_eret;
  reg_idx_t              e_wa, m_wa;
  stage_t                e_tnew, m_tnew;
  logic                  e_mtc0_epc, m_mtc0_epc;
  logic                  md_start, md_is_div;
  logic                  irq_req;
  logic                  stall, bubble_e, flush_all, eret_flush;
  logic                  md_go, md_busy;
  logic [MD_CNT_W-1:0]   md_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md, d_eret,
           e_wa, m_wa, e_tnew, m_tnew, e_mtc0_epc, m_mtc0_epc,
           md_start, md_is_div, irq_req,
    input  stall, bubble_e, flush_all, eret_flush, md_go, md_busy, md_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md, d_eret,
           e_wa, m_wa, e_tnew, m_tnew, e_mtc0_epc, m_mtc0_epc,
           md_start, md_is_div, irq_req,
    output stall, bubble_e, flush_all, eret_flush, md_go, md_busy, md_cnt
  );
endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// md_busy_counter: remaining-cycle counter for the multiply/divide unit.
//   clk, reset (sync, active-high)
//   load    - qualified issue (md_go); loads DIV_CYC or MULT_CYC
//   is_div  - selects the divide latency on load
//   cnt     - remaining busy cycles, decrements to 0 and holds there
//   busy    - cnt != 0 or an issue this cycle
module md_busy_counter import pipe_ctrl_pkg::*; #(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                is_div,
  output logic [MD_CNT_W-1:0] cnt,
  output logic                busy
);
  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYC);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYC);

  // Reset beats load; a load while still counting simply restarts the
  // count with the newer operation's latency.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= is_div ? DIV_LD : MULT_LD;
    else if (cnt != '0)
      cnt <= cnt - MD_CNT_W'(1);
  end

  assign busy = ((cnt != '0) || load) && !reset;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush decisions for a 5-stage MIPS-style pipeline.
//   clk, reset (sync, active-high)
//   hif (slave) - D/E/M hazard info and mult/div issue in; stall,
//                 bubble_e, flush_all, eret_flush, md_go, md_busy,
//                 md_cnt out
// All outputs except md_cnt are combinational from inputs and md_cnt.
module hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hif
);
  logic                md_go;
  logic [MD_CNT_W-1:0] md_cnt;
  logic                md_busy;
  logic                data_hz, epc_hz, md_hz, stall;

  // A producer still tnew cycles away blocks a consumer needing the value
  // in fewer cycles; $0 never hazards and tuse=3 never beats any tnew.
  function automatic logic raw_hz(reg_idx_t src, stage_t tuse,
                                  reg_idx_t wa, stage_t tnew);
    return (src != '0) && (src == wa) && (tuse < tnew);
  endfunction

  // A flushed mult/div must not start the unit.
  assign md_go = hif.md_start && !hif.irq_req && !reset;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (md_go),
    .is_div (hif.md_is_div),
    .cnt    (md_cnt),
    .busy   (md_busy)
  );

  always_comb begin
    data_hz = raw_hz(hif.d_rs, hif.d_tuse_rs, hif.e_wa, hif.e_tnew) ||
              raw_hz(hif.d_rs, hif.d_tuse_rs, hif.m_wa, hif.m_tnew) ||
              raw_hz(hif.d_rt, hif.d_tuse_rt, hif.e_wa, hif.e_tnew) ||
              raw_hz(hif.d_rt, hif.d_tuse_rt, hif.m_wa, hif.m_tnew);
    epc_hz  = hif.d_eret && (hif.e_mtc0_epc || hif.m_mtc0_epc);
    md_hz   = hif.d_md && ((md_cnt != '0) || md_go);
    // Interrupt flush overrides any stall.
    stall   = (data_hz || epc_hz || md_hz) && !hif.irq_req && !reset;
  end

  assign hif.stall      = stall;
  assign hif.bubble_e   = stall;
  assign hif.flush_all  = hif.irq_req && !reset;
  assign hif.eret_flush = hif.d_eret && !stall && !hif.irq_req && !reset;
  assign hif.md_go      = md_go;
  assign hif.md_busy    = md_busy;
  assign hif.md_cnt     = md_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] d_rs, d_rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       d_md, d_eret;
    logic [4:0] e_wa, m_wa;
    logic [1:0] e_tnew, m_tnew;
    logic       e_epc, m_epc, md_start, md_is_div, irq, rst;
  } in_t;

  typedef struct packed {
    logic       stall, bubble_e, flush_all, eret_flush, md_go, md_busy;
    logic [3:0] md_cnt;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  hazard_ctrl_if hif();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.tuse_rs = TUSE_NONE;
    v.tuse_rt = TUSE_NONE;
    return v;
  endfunction

  function automatic exp_t mk(logic s, logic b, logic f, logic r,
                              logic g, logic bz, int cnt);
    exp_t e;
    e.stall = s; e.bubble_e = b; e.flush_all = f; e.eret_flush = r;
    e.md_go = g; e.md_busy = bz; e.md_cnt = 4'(cnt);
    return e;
  endfunction

  task automatic drive(input in_t v);
    hif.d_rs = v.d_rs;         hif.d_rt = v.d_rt;
    hif.d_tuse_rs = v.tuse_rs; hif.d_tuse_rt = v.tuse_rt;
    hif.d_md = v.d_md;         hif.d_eret = v.d_eret;
    hif.e_wa = v.e_wa;         hif.m_wa = v.m_wa;
    hif.e_tnew = v.e_tnew;     hif.m_tnew = v.m_tnew;
    hif.e_mtc0_epc = v.e_epc;  hif.m_mtc0_epc = v.m_epc;
    hif.md_start = v.md_start; hif.md_is_div = v.md_is_div;
    hif.irq_req = v.irq;       reset = v.rst;
  endtask

  // Drive after the falling edge, queue the expectation, then compare the
  // DUT outputs a little later, still clear of the next rising edge.
  task automatic cycle(input string nm, input in_t v, input exp_t e);
    exp_t want, got;
    @(negedge clk);
    drive(v);
    exp_q.push_back(e);
    #2;
    want = exp_q.pop_front();
    got  = {hif.stall, hif.bubble_e, hif.flush_all, hif.eret_flush,
            hif.md_go, hif.md_busy, hif.md_cnt};
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: actual s/b/f/r/go/busy=%b cnt=%0d required s/b/f/r/go/busy=%b cnt=%0d",
                  nm, got[9:4], got.md_cnt, want[9:4], want.md_cnt);
  endtask

  task automatic add(input string nm, input in_t v, input exp_t e);
    vec_t t;
    t.name = nm; t.i = v; t.e = e;
    vecs.push_back(t);
  endtask

  initial begin
    in_t v;

    v = idle(); v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);

    v = idle(); v.rst = 1'b1; v.d_rs = 8; v.tuse_rs = 0; v.e_wa = 8;
    v.e_tnew = 2; v.d_eret = 1; v.irq = 1; v.md_start = 1;
    add("reset_quiet", v, mk(0,0,0,0,0,0,0));
    add("idle", idle(), mk(0,0,0,0,0,0,0));
    v = idle(); v.d_rs = 0; v.tuse_rs = 0; v.e_wa = 0; v.e_tnew = 2;
    add("r0_no_hazard", v, mk(0,0,0,0,0,0,0));
    v = idle(); v.d_rs = 8; v.tuse_rs = 0; v.e_wa = 8; v.e_tnew = 2;
    add("rs_vs_e", v, mk(1,1,0,0,0,0,0));
    v.irq = 1;
    add("irq_over_stall", v, mk(0,0,1,0,0,0,0));
    v = idle(); v.d_rs = 8; v.tuse_rs = 2; v.e_wa = 8; v.e_tnew = 2;
    add("tuse_eq_tnew", v, mk(0,0,0,0,0,0,0));
    v = idle(); v.d_rt = 5; v.tuse_rt = 0; v.m_wa = 5; v.m_tnew = 1;
    add("rt_vs_m", v, mk(1,1,0,0,0,0,0));
    v = idle(); v.d_rt = 5; v.m_wa = 5; v.m_tnew = 2;
    add("rt_unused", v, mk(0,0,0,0,0,0,0));
    v = idle(); v.d_eret = 1; v.e_epc = 1;
    add("eret_vs_e_epc", v, mk(1,1,0,0,0,0,0));
    v = idle(); v.d_eret = 1;
    add("eret_alone", v, mk(0,0,0,1,0,0,0));
    v.irq = 1;
    add("eret_irq", v, mk(0,0,1,0,0,0,0));
    v = idle(); v.d_md = 1;
    add("md_idle", v, mk(0,0,0,0,0,0,0));
    v = idle(); v.d_md = 1; v.md_start = 1; v.irq = 1;
    add("md_start_irq", v, mk(0,0,1,0,0,0,0));
    add("md_not_started", idle(), mk(0,0,0,0,0,0,0));
    v = idle(); v.d_md = 1; v.md_start = 1;
    add("mult_issue", v, mk(1,1,0,0,1,1,0));

    foreach (vecs[k]) cycle(vecs[k].name, vecs[k].i, vecs[k].e);

    // mult countdown following the last table entry: 5 busy cycles
    for (int k = 5; k >= 1; k--) cycle("mult_count", idle(), mk(0,0,0,0,0,1,k));
    cycle("mult_done", idle(), mk(0,0,0,0,0,0,0));

    // load-use through E, then M, then resolved
    v = idle(); v.d_rs = 8; v.tuse_rs = 0; v.e_wa = 8; v.e_tnew = 2;
    cycle("lw_e", v, mk(1,1,0,0,0,0,0));
    v.e_wa = 0; v.e_tnew = 0; v.m_wa = 8; v.m_tnew = 1;
    cycle("lw_m", v, mk(1,1,0,0,0,0,0));
    v.m_tnew = 0;
    cycle("lw_m_ready", v, mk(0,0,0,0,0,0,0));

    // eret behind mtc0 EPC in M
    v = idle(); v.d_eret = 1; v.m_epc = 1;
    cycle("eret_m_epc", v, mk(1,1,0,0,0,0,0));
    v.m_epc = 0;
    cycle("eret_release", v, mk(0,0,0,1,0,0,0));

    // div with a dependent md instruction held in D
    v = idle(); v.d_md = 1; v.md_start = 1; v.md_is_div = 1;
    cycle("div_issue", v, mk(1,1,0,0,1,1,0));
    v.md_start = 0; v.md_is_div = 0;
    for (int k = 10; k >= 1; k--) cycle("div_stall", v, mk(1,1,0,0,0,1,k));
    cycle("div_release", v, mk(0,0,0,0,0,0,0));

    // irq while counting keeps counting; reissue reloads; reset clears
    v = idle(); v.md_start = 1;
    cycle("mult_issue2", v, mk(0,0,0,0,1,1,0));
    v = idle(); v.irq = 1; v.d_md = 1;
    cycle("irq_mid_count", v, mk(0,0,1,0,0,1,5));
    v = idle(); v.md_start = 1; v.md_is_div = 1;
    cycle("reissue_div", v, mk(0,0,0,0,1,1,4));
    cycle("reload_10", idle(), mk(0,0,0,0,0,1,10));
    cycle("count_9", idle(), mk(0,0,0,0,0,1,9));
    cycle("count_8", idle(), mk(0,0,0,0,0,1,8));
    v = idle(); v.rst = 1; v.md_start = 1; v.d_eret = 1; v.d_md = 1;
    v.irq = 1; v.d_rs = 8; v.tuse_rs = 0; v.e_wa = 8; v.e_tnew = 2;
    cycle("reset_at_7", v, mk(0,0,0,0,0,0,7));
    cycle("after_reset", idle(), mk(0,0,0,0,0,0,0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5: busy cycles for mult/multu after issue from E.
REQ-002 Parameter DIV_CYC, default 10: busy cycles for div/divu after issue from E.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 d_rs, d_rt  in  5 each  source register numbers of the D-stage instruction.
REQ-006 d_tuse_rs, d_tuse_rt  in  2 each  cycles until operand use; 3 = operand unused.
REQ-007 d_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 d_eret  in  1  D instruction is eret.
REQ-009 e_wa, m_wa  in  5 each  destination register of E/M instruction; 0 = none.
REQ-010 e_tnew, m_tnew  in  2 each  cycles until E/M result is available.
REQ-011 e_mtc0_epc, m_mtc0_epc  in  1 each  E/M instruction is mtc0 to EPC.
REQ-012 md_start, md_is_div  in  1 each  E issues mult/div this cycle; div when md_is_div=1.
REQ-013 irq_req  in  1  exception/interrupt request from CP0.
REQ-014 stall  out  1  freeze PC and D pipeline register.
REQ-015 bubble_e  out  1  load zero into E pipeline register.
REQ-016 flush_all  out  1  clear D/E/M pipeline registers (IntReq path).
REQ-017 eret_flush  out  1  clear D pipeline register for eret (eretD path).
REQ-018 md_go  out  1  qualified md_start to the mult/div unit.
REQ-019 md_busy  out  1  mult/div unit busy; md_cnt  out  4  remaining busy cycles.

Function
REQ-020 Data hazard: stall=1 when d_rs!=0, d_rs==e_wa and d_tuse_rs<e_tnew; same check for d_rs vs M, and for d_rt vs E and M.
REQ-021 EPC hazard: stall=1 when d_eret and (e_mtc0_epc or m_mtc0_epc).
REQ-022 MD hazard: stall=1 when d_md and (md_cnt!=0 or md_go).
REQ-023 bubble_e equals stall whenever irq_req=0.
REQ-024 md_go = md_start and not irq_req; a flushed mult/div never starts.
REQ-025 Counter: on md_go, md_cnt loads DIV_CYC if md_is_div else MULT_CYC; otherwise decrements by 1 while nonzero; saturates at 0.
REQ-026 md_busy = (md_cnt!=0) or md_go; single busy cycle count equals parameter exactly (mult: 5 cycles with md_busy=1 after the issue cycle inclusive of countdown 5..1).
REQ-027 irq_req has top priority: flush_all=1, stall=0, bubble_e=0, eret_flush=0 in that cycle; a running md_cnt keeps counting (issued op completes).
REQ-028 eret_flush = d_eret and not stall and not irq_req.
REQ-029 All outputs except md_cnt are combinational from inputs and md_cnt; zero added latency.
REQ-030 md_start while md_cnt!=0 is a protocol error; counter reloads (later op wins), no assertion output.

Reset
REQ-031 On reset: md_cnt=0; hence md_busy=0, md_go=0 in the reset cycle; stall/bubble_e/flush_all/eret_flush=0 during reset.
REQ-032 Reset mid-countdown clears md_cnt in the next cycle regardless of md_go.

Structure
REQ-033 Shared package pipe_ctrl_pkg: TUSE_NONE=3 encoding, MULT_CYC/DIV_CYC defaults, md_cnt width constant.
REQ-034 One sub-module md_busy_counter (load/decrement/saturate counter, REQ-025/026/032); hazard comparisons stay in hazard_ctrl.

Verification
REQ-035 e_wa=8,e_tnew=2 (lw), d_rs=8,d_tuse_rs=0 -> stall=1,bubble_e=1; next cycle m_wa=8,m_tnew=1 -> stall=1; then m_tnew=0 -> stall=0.
REQ-036 d_rs=0,e_wa=0,e_tnew=2,d_tuse_rs=0 -> stall=0 ($0 never hazards).
REQ-037 md_start=1,md_is_div=1 -> md_cnt 10,9..1,0 on following cycles; d_md=1 held -> stall=1 until md_cnt=0, released same cycle md_cnt=0.
REQ-038 md_start=1 with irq_req=1 -> md_go=0, md_cnt stays 0, flush_all=1, stall=0.
REQ-039 d_eret=1,m_mtc0_epc=1 -> stall=1,eret_flush=0; next cycle m_mtc0_epc=0 -> eret_flush=1.
REQ-040 reset=1 with md_cnt=7 -> md_cnt=0, md_busy=0 next cycle; all flush/stall outputs 0 during reset.
